// File: rtl/mac_pkg.sv
// mac_pkg: state encoding and width/saturation helpers shared by the systolic MAC row.
package mac_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_e;

    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

    function automatic int prod_w(input int data_w);
        return 2 * data_w;
    endfunction

    // Operands arrive already extended to 64 bits; result is clamped to a w-bit range.
    function automatic logic [63:0] sat_add(input logic [63:0] acc, input logic [63:0] inc,
                                            input int w, input logic sgn, output logic ovf);
        logic [63:0] sum, hi, lo;
        logic over, under;
        sum   = acc + inc;
        hi    = sgn ? (64'd1 << (w - 1)) - 64'd1 : (64'd1 << w) - 64'd1;
        lo    = sgn ? ~hi : 64'd0;
        over  = sgn ? $signed(sum) > $signed(hi) : sum > hi;
        under = sgn && $signed(sum) < $signed(lo);
        ovf   = over || under;
        return over ? hi : under ? lo : sum;
    endfunction

endpackage

// File: rtl/mac_pe.sv
// mac_pe: one systolic processing element; forwards A/valid to the next PE and
// saturating-accumulates a*b on every valid beat.
module mac_pe
    import mac_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20,
    parameter int SIGNED = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              v_in,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic [DATA_W-1:0] a_out,
    output logic              v_out,
    output logic [ACC_W-1:0]  acc,
    output logic              sat
);
    // Two guard bits let one signed multiplier serve both signed and unsigned operands.
    localparam int PW = prod_w(DATA_W) + 2;
    localparam bit SX = SIGNED != 0;

    logic signed [PW-1:0] a_ext, b_ext, prod;
    logic [63:0]          sum;
    logic                 ovf, unused_hi;
    logic [DATA_W-1:0]    a_q, a_d;
    logic                 v_q, v_d, sat_q, sat_d;
    logic [ACC_W-1:0]     acc_q, acc_d;

    always_comb begin
        ovf   = 1'b0;
        a_ext = {{(DATA_W + 2){SX & a_in[DATA_W-1]}}, a_in};
        b_ext = {{(DATA_W + 2){SX & b_in[DATA_W-1]}}, b_in};
        prod  = a_ext * b_ext;
        sum   = sat_add({{(64 - ACC_W){SX & acc_q[ACC_W-1]}}, acc_q},
                        {{(64 - PW){prod[PW-1]}}, prod}, ACC_W, SX, ovf);
        a_d   = a_in;
        v_d   = v_in;
        acc_d = clear ? '0 : v_in ? sum[ACC_W-1:0] : acc_q;
        sat_d = !clear && (sat_q || (v_in && ovf));
    end

    assign unused_hi = ^sum[63:ACC_W];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q   <= '0;
            v_q   <= 1'b0;
            acc_q <= '0;
            sat_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            v_q   <= v_d;
            acc_q <= acc_d;
            sat_q <= sat_d;
        end
    end

    assign a_out = a_q;
    assign v_out = v_q;
    assign acc   = acc_q;
    assign sat   = sat_q;

endmodule

// File: rtl/systolic_mac_row.sv
// systolic_mac_row: 1-D chain of MAC PEs with job FSM, per-lane B skew and a
// valid/ready result drain, one PE result per handshake.
module systolic_mac_row
    import mac_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20,
    parameter int NUM_PE = 4,
    parameter int K_W    = 8,
    parameter int SIGNED = 1,
    localparam int IDX_W = idx_w(NUM_PE)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [K_W-1:0]           cfg_k,
    output logic                     busy,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_a,
    input  logic [NUM_PE*DATA_W-1:0] in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_W-1:0]         out_data,
    output logic [IDX_W-1:0]         out_idx,
    output logic                     out_last,
    output logic                     sat_flag
);
    state_e                          state_q, state_d;
    logic [K_W-1:0]                  k_q, k_d, cnt_q, cnt_d;
    logic [IDX_W-1:0]                fcnt_q, fcnt_d, idx_q, idx_d;
    logic                            out_valid_q, out_valid_d, clear, accept, hs, unused_tail;
    logic [NUM_PE:0][DATA_W-1:0]     a_pipe;
    logic [NUM_PE:0]                 v_pipe;
    logic [NUM_PE-1:0][DATA_W-1:0]   b_lane;
    logic [NUM_PE-1:0][ACC_W-1:0]    acc;
    logic [NUM_PE-1:0]               sat;

    assign accept    = in_valid && state_q == LOAD;
    assign hs        = out_valid_q && out_ready;
    assign a_pipe[0] = in_a;
    assign v_pipe[0] = accept;

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        cnt_d       = cnt_q;
        fcnt_d      = fcnt_q;
        idx_d       = idx_q;
        clear       = 1'b0;
        out_valid_d = state_q == DRAIN && !(hs && out_last);
        case (state_q)
            IDLE: if (start) begin
                clear   = 1'b1;
                k_d     = cfg_k;
                cnt_d   = '0;
                idx_d   = '0;
                state_d = cfg_k != '0 ? LOAD : DRAIN;
            end
            LOAD: if (accept) begin
                cnt_d  = cnt_q + 1'b1;
                fcnt_d = '0;
                if (cnt_d == k_q) state_d = NUM_PE == 1 ? DRAIN : FLUSH;
            end
            FLUSH: begin
                fcnt_d  = fcnt_q + 1'b1;
                state_d = fcnt_q == IDX_W'(NUM_PE - 2) ? DRAIN : FLUSH;
            end
            DRAIN: if (hs) begin
                idx_d   = out_last ? '0 : idx_q + 1'b1;
                state_d = out_last ? IDLE : DRAIN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            k_q         <= '0;
            cnt_q       <= '0;
            fcnt_q      <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            fcnt_q      <= fcnt_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
        end
    end

    for (genvar i = 0; i < NUM_PE; i++) begin : g_pe
        if (i == 0) begin : g_b0
            assign b_lane[i] = in_b[0 +: DATA_W];
        end else begin : g_skew
            // Lane i lags by i cycles so it meets the A beat it was issued with.
            logic [DATA_W-1:0] sk_q [i];
            logic [DATA_W-1:0] sk_d [i];
            always_comb begin
                sk_d[0] = in_b[i*DATA_W +: DATA_W];
                for (int j = 1; j < i; j++) sk_d[j] = sk_q[j-1];
            end
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) sk_q <= '{default: '0};
                else        sk_q <= sk_d;
            end
            assign b_lane[i] = sk_q[i-1];
        end
        mac_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W), .SIGNED(SIGNED)) u_pe (
            .clk  (clk),
            .reset(reset),
            .clear(clear),
            .v_in (v_pipe[i]),
            .a_in (a_pipe[i]),
            .b_in (b_lane[i]),
            .a_out(a_pipe[i+1]),
            .v_out(v_pipe[i+1]),
            .acc  (acc[i]),
            .sat  (sat[i])
        );
    end

    assign unused_tail = ^{a_pipe[NUM_PE], v_pipe[NUM_PE]};
    assign busy        = state_q != IDLE;
    assign in_ready    = state_q == LOAD;
    assign out_valid   = out_valid_q;
    assign out_idx     = idx_q;
    assign out_last    = out_valid_q && idx_q == IDX_W'(NUM_PE - 1);
    assign out_data    = out_valid_q ? acc[idx_q] : '0;
    assign sat_flag    = |sat;

endmodule

// File: tb/tb_systolic_mac_row.sv
// tb_systolic_mac_row: directed self-checking bench for the 4-PE signed MAC row.
module tb_systolic_mac_row;
    localparam int DW = 8;
    localparam int AW = 20;
    localparam int NP = 4;
    localparam int KW = 8;

    logic              clk = 1'b0, reset = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [KW-1:0]     cfg_k = '0;
    logic [DW-1:0]     in_a = '0;
    logic [NP*DW-1:0]  in_b = '0;
    logic              busy, in_ready, out_valid, out_last, sat_flag;
    logic [AW-1:0]     out_data;
    logic [1:0]        out_idx;
    int                n_chk = 0, n_fail = 0;

    systolic_mac_row #(.DATA_W(DW), .ACC_W(AW), .NUM_PE(NP), .K_W(KW), .SIGNED(1)) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_k(cfg_k), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [KW-1:0] k);
        start = 1'b1;
        cfg_k = k;
        tick();
        start = 1'b0;
        cfg_k = KW'($urandom);
    endtask

    task automatic beat(input logic [DW-1:0] a, input logic [NP*DW-1:0] b, input int gap);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        tick();
        in_valid = 1'b0;
        in_a     = DW'($urandom);
        in_b     = 32'($urandom);
        repeat (gap) tick();
    endtask

    task automatic wait_valid(input string tag, input int exp_cycles);
        int c = 0;
        while (!out_valid && c < 20) begin
            tick();
            c++;
        end
        chk(tag, c, exp_cycles);
    endtask

    task automatic drain(input string tag, input logic [AW-1:0] e0, e1, e2, e3,
                         input int stall_idx, input int stall_n);
        logic [AW-1:0] e [4];
        e = '{e0, e1, e2, e3};
        for (int i = 0; i < NP; i++) begin
            chk({tag, "_valid"}, out_valid, 1);
            chk({tag, "_idx"}, out_idx, i);
            chk({tag, "_data"}, out_data, e[i]);
            chk({tag, "_last"}, out_last, i == NP - 1);
            if (i == stall_idx) begin
                repeat (stall_n) begin
                    tick();
                    chk({tag, "_stall_valid"}, out_valid, 1);
                    chk({tag, "_stall_idx"}, out_idx, i);
                    chk({tag, "_stall_data"}, out_data, e[i]);
                end
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_valid_end"}, out_valid, 0);
    endtask

    initial begin
        // 1: reset holds every output at zero regardless of inputs
        for (int i = 0; i < 4; i++) begin
            start     = 1'($urandom);
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            cfg_k     = KW'($urandom);
            in_a      = DW'($urandom);
            in_b      = 32'($urandom);
            tick();
            chk("rst_outputs", {busy, in_ready, out_valid, out_last, sat_flag, out_idx, out_data}, 0);
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cfg_k = '0;
        #3 reset = 1'b1;
        tick();
        chk("rel_busy", busy, 0);
        chk("rel_in_ready", in_ready, 0);

        // 2: basic 3-beat job
        go(3);
        chk("t2_busy", busy, 1);
        chk("t2_in_ready", in_ready, 1);
        beat(8'd1, 32'h04030201, 0);
        beat(8'd2, 32'h04030201, 0);
        beat(8'd3, 32'h04030201, 0);
        chk("t2_in_ready_off", in_ready, 0);
        wait_valid("t2_latency", 4);
        out_ready = 1'b1;
        for (int i = 0; i < NP; i++) begin
            chk("t2_idx", out_idx, i);
            chk("t2_data", out_data, 6 * (i + 1));
            chk("t2_last", out_last, i == NP - 1);
            tick();
        end
        out_ready = 1'b0;
        chk("t2_busy_end", busy, 0);

        // 3: bubbles between beats and an ignored start during the job
        go(3);
        beat(8'd1, 32'h04030201, 0);
        start = 1'b1; cfg_k = 8'd7;
        tick();
        start = 1'b0;
        tick();
        beat(8'd2, 32'h04030201, 2);
        beat(8'd3, 32'h04030201, 0);
        wait_valid("t3_latency", 4);
        drain("t3", 20'd6, 20'd12, 20'd18, 20'd24, -1, 0);

        // 4: saturation on every PE, then cleared by the next job
        go(32);
        for (int i = 0; i < 32; i++) beat(8'h80, 32'h80808080, 0);
        wait_valid("t4_latency", 4);
        chk("t4_sat", sat_flag, 1);
        drain("t4", 20'h7FFFF, 20'h7FFFF, 20'h7FFFF, 20'h7FFFF, -1, 0);
        chk("t4_sat_hold", sat_flag, 1);
        go(1);
        chk("t4_sat_clr", sat_flag, 0);
        beat(8'd0, 32'h0, 0);
        wait_valid("t4b_latency", 4);
        drain("t4b", 20'd0, 20'd0, 20'd0, 20'd0, -1, 0);
        chk("t4b_sat", sat_flag, 0);

        // 5: backpressure at idx 1
        go(1);
        beat(8'd1, 32'h08070605, 0);
        wait_valid("t5_latency", 4);
        drain("t5", 20'd5, 20'd6, 20'd7, 20'd8, 1, 5);

        // 6: reset mid-LOAD, then a zero-length job
        go(5);
        beat(8'd3, 32'h01010101, 0);
        beat(8'd3, 32'h01010101, 0);
        in_valid = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("t6_rst_outputs", {busy, in_ready, out_valid, out_last, sat_flag, out_idx, out_data}, 0);
        tick();
        tick();
        in_valid = 1'b0;
        #3 reset = 1'b1;
        tick();
        chk("t6_idle", busy, 0);
        go(0);
        chk("t6_k0_busy", busy, 1);
        chk("t6_k0_in_ready", in_ready, 0);
        wait_valid("t6_k0_latency", 1);
        chk("t6_k0_in_ready2", in_ready, 0);
        drain("t6", 20'd0, 20'd0, 20'd0, 20'd0, -1, 0);
        chk("t6_sat", sat_flag, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
